mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter between the instruction cache and data cache miss ports and the single memory bus. It multiplexes `MemBusReq` traffic from both caches onto one memory port and routes each read response back to the cache that issued the read. It sits directly downstream of the data cache's bus port and the instruction cache's bus port, and directly upstream of the memory controller. Only one read is in flight at a time; writes are posted and get no response.

---
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter: I-cache and D-cache miss ports share one memory bus, one read in flight.
// Latency: zero added cycles on both the request path and the response path.
// Backpressure: memory ready reaches the granted side only; the other side sees ready=0 and holds.
module mem_bus_arbiter #(
  parameter bit PRIORITY_D = 1'b0,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  // I-cache bus port
  input  logic              ireq_in_valid,
  input  logic [ADDR_W-1:0] ireq_in_addr,
  input  logic              ireq_in_wen,
  input  logic [DATA_W-1:0] ireq_in_wdata,
  output logic              ireq_in_ready,
  output logic              iresp_in_valid,
  output logic [DATA_W-1:0] iresp_in_rdata,
  // D-cache bus port
  input  logic              dreq_in_valid,
  input  logic [ADDR_W-1:0] dreq_in_addr,
  input  logic              dreq_in_wen,
  input  logic [DATA_W-1:0] dreq_in_wdata,
  output logic              dreq_in_ready,
  output logic              dresp_in_valid,
  output logic [DATA_W-1:0] dresp_in_rdata,
  // Memory controller port
  output logic              memreq_valid,
  output logic [ADDR_W-1:0] memreq_addr,
  output logic              memreq_wen,
  output logic [DATA_W-1:0] memreq_wdata,
  input  logic              memreq_ready,
  input  logic              memresp_valid,
  input  logic [DATA_W-1:0] memresp_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant_d;  // 1: D side won the most recent accepted request
  logic   sel_d;         // 1: D side is the current candidate for the bus
  logic   accept;

  // Pick a side: a lone requester wins; a tie goes to D in priority mode, else to the side that did not win last
  always_comb begin
    sel_d = 1'b0;
    if (ireq_in_valid && dreq_in_valid) begin
      sel_d = PRIORITY_D ? 1'b1 : !last_grant_d;
    end else begin
      sel_d = dreq_in_valid;
    end
  end

  assign accept = !reset && (state == IDLE) && memreq_valid && memreq_ready;

  // State and grant history; the D-side reset value hands the first round-robin tie to I
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant_d <= sel_d;
      end
    end
  end

  // Reads park the FSM until memory answers; posted writes leave it in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !memreq_wen) begin
          state_nxt = sel_d ? WAIT_D : WAIT_I;
        end
      end
      WAIT_I, WAIT_D: begin
        if (memresp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational request mux and response steering, all quiet while reset is high
  always_comb begin
    memreq_valid   = 1'b0;
    ireq_in_ready  = 1'b0;
    dreq_in_ready  = 1'b0;
    iresp_in_valid = 1'b0;
    dresp_in_valid = 1'b0;
    memreq_addr    = sel_d ? dreq_in_addr  : ireq_in_addr;
    memreq_wen     = sel_d ? dreq_in_wen   : ireq_in_wen;
    memreq_wdata   = sel_d ? dreq_in_wdata : ireq_in_wdata;
    iresp_in_rdata = memresp_rdata;
    dresp_in_rdata = memresp_rdata;
    if (!reset) begin
      if (state == IDLE) begin
        memreq_valid  = sel_d ? dreq_in_valid : ireq_in_valid;
        ireq_in_ready = !sel_d && ireq_in_valid && memreq_ready;
        dreq_in_ready = sel_d && memreq_ready;
      end
      iresp_in_valid = (state == WAIT_I) && memresp_valid;
      dresp_in_valid = (state == WAIT_D) && memresp_valid;
    end
  end

  // A response with no read outstanding means the memory side is out of step
  a_no_stray_resp : assert property (@(posedge clk) disable iff (reset)
    !((state == IDLE) && memresp_valid))
    else $fatal(1, "mem_bus_arbiter : unexpected resp");

  // The state register must only ever hold one of the three encodings
  a_known_state : assert property (@(posedge clk) disable iff (reset)
    state inside {IDLE, WAIT_I, WAIT_D})
    else $fatal(1, "mem_bus_arbiter : unknown state");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: round-robin and D-priority instances side by side.
// Vector table, directed multi-cycle sequences, then randomized traffic against a reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        iv; logic [31:0] ia; logic iw; logic [31:0] id;
    logic        dv; logic [31:0] da; logic dw; logic [31:0] dd;
    logic        mr; logic        rv; logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic mv; logic [31:0] ma; logic mw; logic [31:0] md;
    logic ir; logic dr;
    logic irv; logic [31:0] ird; logic drv; logic [31:0] drd;
  } out_t;

  typedef struct {
    int owner;   // 0 none, 1 I-side read outstanding, 2 D-side read outstanding
    bit last_d;  // previous winner was D
    int dly;     // cycles until memory answers the outstanding read
  } mdl_t;

  typedef struct {
    logic iv; logic [31:0] ia; logic iw;
    logic dv; logic [31:0] da; logic dw;
    logic mr;
    logic emv; logic [31:0] ema; logic eir; logic edr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  in_r, in_p;
  out_t out_r, out_p;
  int   errors = 0;
  int   checks = 0;

  logic r_mv, r_mw, r_ir, r_dr, r_irv, r_drv;
  logic [31:0] r_ma, r_md, r_ird, r_drd;
  logic p_mv, p_mw, p_ir, p_dr, p_irv, p_drv;
  logic [31:0] p_ma, p_md, p_ird, p_drd;

  assign out_r = {r_mv, r_ma, r_mw, r_md, r_ir, r_dr, r_irv, r_ird, r_drv, r_drd};
  assign out_p = {p_mv, p_ma, p_mw, p_md, p_ir, p_dr, p_irv, p_ird, p_drv, p_drd};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.PRIORITY_D(1'b0)) dut_rr (
    .clk(clk), .reset(rst),
    .ireq_in_valid(in_r.iv), .ireq_in_addr(in_r.ia), .ireq_in_wen(in_r.iw), .ireq_in_wdata(in_r.id),
    .ireq_in_ready(r_ir), .iresp_in_valid(r_irv), .iresp_in_rdata(r_ird),
    .dreq_in_valid(in_r.dv), .dreq_in_addr(in_r.da), .dreq_in_wen(in_r.dw), .dreq_in_wdata(in_r.dd),
    .dreq_in_ready(r_dr), .dresp_in_valid(r_drv), .dresp_in_rdata(r_drd),
    .memreq_valid(r_mv), .memreq_addr(r_ma), .memreq_wen(r_mw), .memreq_wdata(r_md),
    .memreq_ready(in_r.mr), .memresp_valid(in_r.rv), .memresp_rdata(in_r.rd)
  );

  mem_bus_arbiter #(.PRIORITY_D(1'b1)) dut_pd (
    .clk(clk), .reset(rst),
    .ireq_in_valid(in_p.iv), .ireq_in_addr(in_p.ia), .ireq_in_wen(in_p.iw), .ireq_in_wdata(in_p.id),
    .ireq_in_ready(p_ir), .iresp_in_valid(p_irv), .iresp_in_rdata(p_ird),
    .dreq_in_valid(in_p.dv), .dreq_in_addr(in_p.da), .dreq_in_wen(in_p.dw), .dreq_in_wdata(in_p.dd),
    .dreq_in_ready(p_dr), .dresp_in_valid(p_drv), .dresp_in_rdata(p_drd),
    .memreq_valid(p_mv), .memreq_addr(p_ma), .memreq_wen(p_mw), .memreq_wdata(p_md),
    .memreq_ready(in_p.mr), .memresp_valid(in_p.rv), .memresp_rdata(in_p.rd)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    in_r = '0;
    in_p = '0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  // New requests appear only on idle sides; a pending request is held unchanged until accepted
  function automatic in_t gen(input in_t x, input mdl_t s);
    in_t y = x;
    if (!y.iv && $urandom_range(0, 1) == 1) begin
      y.iv = 1'b1; y.ia = $urandom; y.iw = ($urandom_range(0, 2) == 0); y.id = $urandom;
    end
    if (!y.dv && $urandom_range(0, 1) == 1) begin
      y.dv = 1'b1; y.da = $urandom; y.dw = ($urandom_range(0, 2) == 0); y.dd = $urandom;
    end
    y.mr = ($urandom_range(0, 3) != 0);
    y.rv = (s.owner != 0) && (s.dly == 0);
    y.rd = $urandom;
    return y;
  endfunction

  task automatic predict(input in_t x, input mdl_t s, input bit pd, output out_t e, output bit take_d);
    e = '0;
    if (x.iv && x.dv) take_d = pd ? 1'b1 : !s.last_d;
    else              take_d = x.dv;
    if (s.owner == 0 && (x.iv || x.dv)) begin
      e.mv = 1'b1;
      if (take_d) begin
        e.ma = x.da; e.mw = x.dw; e.md = x.dd; e.dr = x.mr;
      end else begin
        e.ma = x.ia; e.mw = x.iw; e.md = x.id; e.ir = x.mr;
      end
    end
    e.irv = (s.owner == 1) && x.rv;
    e.drv = (s.owner == 2) && x.rv;
    e.ird = x.rd;
    e.drd = x.rd;
  endtask

  task automatic cmp(input string tag, input out_t e, input out_t a, input in_t x);
    chk({tag, " memreq.valid"}, 32'(a.mv), 32'(e.mv));
    if (e.mv) begin
      chk({tag, " memreq.addr"}, a.ma, e.ma);
      chk({tag, " memreq.wen"}, 32'(a.mw), 32'(e.mw));
      chk({tag, " memreq.wdata"}, a.md, e.md);
    end
    if (x.iv) chk({tag, " ireq.ready"}, 32'(a.ir), 32'(e.ir));
    if (x.dv) chk({tag, " dreq.ready"}, 32'(a.dr), 32'(e.dr));
    chk({tag, " iresp.valid"}, 32'(a.irv), 32'(e.irv));
    chk({tag, " dresp.valid"}, 32'(a.drv), 32'(e.drv));
    if (e.irv) chk({tag, " iresp.rdata"}, a.ird, e.ird);
    if (e.drv) chk({tag, " dresp.rdata"}, a.drd, e.drd);
  endtask

  task automatic upd(inout mdl_t s, inout in_t x, input out_t e, input bit take_d);
    if (e.mv && x.mr) begin
      s.last_d = take_d;
      if (!(take_d ? x.dw : x.iw)) begin
        s.owner = take_d ? 2 : 1;
        s.dly   = $urandom_range(0, 3);
      end
      if (take_d) x.dv = 1'b0;
      else        x.iv = 1'b0;
    end else if (s.owner != 0) begin
      if (x.rv) s.owner = 0;
      else      s.dly--;
    end
  endtask

  initial begin
    vec_t tv[9];
    mdl_t m0, m1;
    out_t e0, e1;
    bit   t0, t1;
    int   nresp;

    // Fresh from reset (last winner D); rows with ready=1 carry writes so state stays IDLE
    //         iv  ia     iw  dv  da     dw  mr  emv ema    eir edr
    tv[0] = '{0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 0};
    tv[1] = '{1, 32'h10, 0, 0, 32'h0,  0, 0, 1, 32'h10, 0, 0};
    tv[2] = '{0, 32'h0,  0, 1, 32'h20, 0, 0, 1, 32'h20, 0, 0};
    tv[3] = '{1, 32'h10, 0, 1, 32'h20, 0, 0, 1, 32'h10, 0, 0};
    tv[4] = '{1, 32'h30, 1, 1, 32'h40, 1, 1, 1, 32'h30, 1, 0};
    tv[5] = '{1, 32'h30, 1, 1, 32'h40, 1, 1, 1, 32'h40, 0, 1};
    tv[6] = '{1, 32'h50, 1, 1, 32'h60, 1, 1, 1, 32'h50, 1, 0};
    tv[7] = '{1, 32'h70, 1, 0, 32'h0,  0, 1, 1, 32'h70, 1, 0};
    tv[8] = '{1, 32'h80, 0, 1, 32'h90, 0, 0, 1, 32'h90, 0, 0};

    // Outputs forced low under reset even with live requests and a response on the bus
    rst  = 1'b1;
    in_r = '0; in_p = '0;
    in_r.iv = 1; in_r.dv = 1; in_r.mr = 1; in_r.rv = 1;
    in_p.iv = 1; in_p.dv = 1; in_p.mr = 1;
    adv();
    settle();
    chk("reset memreq.valid", 32'(r_mv), 0);
    chk("reset ireq.ready", 32'(r_ir), 0);
    chk("reset dreq.ready", 32'(r_dr), 0);
    chk("reset iresp.valid", 32'(r_irv), 0);
    chk("reset dresp.valid", 32'(r_drv), 0);
    chk("reset pd memreq.valid", 32'(p_mv), 0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      in_r.iv = tv[i].iv; in_r.ia = tv[i].ia; in_r.iw = tv[i].iw;
      in_r.dv = tv[i].dv; in_r.da = tv[i].da; in_r.dw = tv[i].dw;
      in_r.mr = tv[i].mr;
      settle();
      chk($sformatf("vec%0d memreq.valid", i), 32'(r_mv), 32'(tv[i].emv));
      if (tv[i].emv) chk($sformatf("vec%0d memreq.addr", i), r_ma, tv[i].ema);
      chk($sformatf("vec%0d ireq.ready", i), 32'(r_ir), 32'(tv[i].eir));
      chk($sformatf("vec%0d dreq.ready", i), 32'(r_dr), 32'(tv[i].edr));
      adv();
    end

    // Single I read at 0x100: ready one cycle late, response three cycles after acceptance
    do_reset();
    in_r.iv = 1; in_r.ia = 32'h100;
    settle(); chk("A wait memreq.addr", r_ma, 32'h100); chk("A wait ireq.ready", 32'(r_ir), 0);
    adv(); in_r.mr = 1;
    settle(); chk("A accept ireq.ready", 32'(r_ir), 1);
    adv(); in_r.iv = 0; in_r.mr = 0;
    settle(); chk("A busy memreq.valid", 32'(r_mv), 0); chk("A busy iresp.valid", 32'(r_irv), 0);
    adv();
    adv(); in_r.rv = 1; in_r.rd = 32'hDEADBEEF;
    settle(); chk("A iresp.valid", 32'(r_irv), 1); chk("A iresp.rdata", r_ird, 32'hDEADBEEF);
    chk("A dresp.valid", 32'(r_drv), 0);
    adv(); in_r.rv = 0;
    settle(); chk("A iresp one cycle", 32'(r_irv), 0);

    // Simultaneous reads after reset: I first, D once I's response has returned
    do_reset();
    in_r.iv = 1; in_r.ia = 32'h200; in_r.dv = 1; in_r.da = 32'h300; in_r.mr = 1;
    settle(); chk("B first memreq.addr", r_ma, 32'h200); chk("B first ireq.ready", 32'(r_ir), 1);
    chk("B first dreq.ready", 32'(r_dr), 0);
    adv(); in_r.iv = 0;
    settle(); chk("B busy dreq.ready", 32'(r_dr), 0);
    adv(); in_r.rv = 1; in_r.rd = 32'hAAAA0001;
    settle(); chk("B iresp.valid", 32'(r_irv), 1); chk("B iresp.rdata", r_ird, 32'hAAAA0001);
    chk("B no dresp", 32'(r_drv), 0); chk("B resp-cycle dreq.ready", 32'(r_dr), 0);
    adv(); in_r.rv = 0;
    settle(); chk("B second memreq.addr", r_ma, 32'h300); chk("B second dreq.ready", 32'(r_dr), 1);
    adv(); in_r.dv = 0;
    adv(); in_r.rv = 1; in_r.rd = 32'hBBBB0002;
    settle(); chk("B dresp.valid", 32'(r_drv), 1); chk("B dresp.rdata", r_drd, 32'hBBBB0002);
    chk("B no iresp", 32'(r_irv), 0);
    adv(); in_r.rv = 0;

    // D priority: D wins every round while both request; I only gets in once D drops
    in_p.iv = 1; in_p.ia = 32'h800; in_p.dv = 1; in_p.da = 32'h900; in_p.mr = 1;
    for (int k = 0; k < 3; k++) begin
      settle(); chk($sformatf("C%0d memreq.addr", k), p_ma, 32'h900);
      chk($sformatf("C%0d dreq.ready", k), 32'(p_dr), 1); chk($sformatf("C%0d ireq.ready", k), 32'(p_ir), 0);
      adv();
      settle(); chk($sformatf("C%0d busy ireq.ready", k), 32'(p_ir), 0);
      adv(); in_p.rv = 1; in_p.rd = 32'hD000 + 32'(k);
      settle(); chk($sformatf("C%0d dresp.valid", k), 32'(p_drv), 1);
      chk($sformatf("C%0d iresp.valid", k), 32'(p_irv), 0);
      adv(); in_p.rv = 0;
    end
    in_p.dv = 0;
    settle(); chk("C I memreq.addr", p_ma, 32'h800); chk("C I ireq.ready", 32'(p_ir), 1);
    adv(); in_p.iv = 0;
    adv(); in_p.rv = 1; in_p.rd = 32'h1234;
    settle(); chk("C iresp.valid", 32'(p_irv), 1);
    adv(); in_p.rv = 0;

    // D write-back then D read on consecutive cycles with memory always ready
    do_reset();
    in_r.mr = 1; in_r.dv = 1; in_r.da = 32'h400; in_r.dw = 1; in_r.dd = 32'h11112222;
    settle(); chk("D wr memreq.addr", r_ma, 32'h400); chk("D wr memreq.wen", 32'(r_mw), 1);
    chk("D wr memreq.wdata", r_md, 32'h11112222); chk("D wr dreq.ready", 32'(r_dr), 1);
    adv(); in_r.da = 32'h500; in_r.dw = 0;
    settle(); chk("D rd memreq.valid", 32'(r_mv), 1); chk("D rd memreq.addr", r_ma, 32'h500);
    chk("D rd dreq.ready", 32'(r_dr), 1);
    adv(); in_r.dv = 0;
    nresp = 0;
    for (int k = 0; k < 4; k++) begin
      in_r.rv = (k == 1);
      settle(); if (r_drv === 1'b1) nresp++;
      adv();
    end
    in_r.rv = 0;
    chk("D dresp count", 32'(nresp), 1);

    // Reset lands while a D read is outstanding; the late response must not reach D
    in_r.dv = 1; in_r.da = 32'h640; in_r.mr = 1;
    adv(); in_r.dv = 0;
    rst = 1; in_r.iv = 1; in_r.ia = 32'h600; in_r.rv = 1;
    settle(); chk("E rst memreq.valid", 32'(r_mv), 0); chk("E rst ireq.ready", 32'(r_ir), 0);
    chk("E rst dreq.ready", 32'(r_dr), 0); chk("E rst iresp.valid", 32'(r_irv), 0);
    chk("E rst dresp.valid", 32'(r_drv), 0);
    adv(); adv(); rst = 0; in_r.rv = 0;
    settle(); chk("E memreq.addr", r_ma, 32'h600); chk("E ireq.ready", 32'(r_ir), 1);
    adv(); in_r.iv = 0; in_r.rv = 1; in_r.rd = 32'h0BAD0BAD;
    settle(); chk("E stale dresp.valid", 32'(r_drv), 0);
    adv(); in_r.rv = 0;

    // Memory stalls five cycles: request held on the bus, accepted on the ready cycle
    in_r.iv = 1; in_r.ia = 32'h700; in_r.mr = 0;
    for (int k = 0; k < 5; k++) begin
      settle(); chk($sformatf("F%0d memreq.valid", k), 32'(r_mv), 1);
      chk($sformatf("F%0d memreq.addr", k), r_ma, 32'h700);
      chk($sformatf("F%0d ireq.ready", k), 32'(r_ir), 0);
      adv();
    end
    in_r.mr = 1;
    settle(); chk("F accept ireq.ready", 32'(r_ir), 1);
    adv(); in_r.iv = 0;
    settle(); chk("F busy memreq.valid", 32'(r_mv), 0);
    adv(); in_r.rv = 1; in_r.rd = 32'h77;
    settle(); chk("F iresp.valid", 32'(r_irv), 1);
    adv(); in_r.rv = 0;

    // Randomized traffic on both instances against the reference model
    do_reset();
    m0 = '{owner: 0, last_d: 1'b1, dly: 0};
    m1 = '{owner: 0, last_d: 1'b1, dly: 0};
    for (int c = 0; c < 1500; c++) begin
      in_r = gen(in_r, m0);
      in_p = gen(in_p, m1);
      predict(in_r, m0, 1'b0, e0, t0);
      predict(in_p, m1, 1'b1, e1, t1);
      settle();
      cmp("rnd rr", e0, out_r, in_r);
      cmp("rnd pd", e1, out_p, in_p);
      adv();
      upd(m0, in_r, e0, t0);
      upd(m1, in_p, e1, t1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
